// File: rtl/car_sequencer_pkg.sv
// car_sequencer_pkg
//   Shared definitions for the micro-sequencer and the ControlUnit:
//   CAR state codes, instruction format/opcode constants and addressing-mode
//   codes. Both blocks import this package so CAR codes cannot diverge.
package car_sequencer_pkg;

    localparam int CAR_W = 6;

    typedef enum logic [CAR_W-1:0] {
        S_RESET       = 6'd0,
        S_FETCH       = 6'd1,
        S_DECODE      = 6'd2,
        S_SRC_EXT     = 6'd3,
        S_SRC_READ    = 6'd4,
        S_DST_EXT     = 6'd5,
        S_DST_READ    = 6'd6,
        S_EXEC        = 6'd7,
        S_WRITE       = 6'd8,
        S_PUSH_DEC    = 6'd9,
        S_PUSH_WR     = 6'd10,
        S_POP_SR      = 6'd11,
        S_POP_PC      = 6'd12,
        S_INT_PUSH_PC = 6'd13,
        S_INT_PUSH_SR = 6'd14,
        S_INT_VECTOR  = 6'd15,
        S_INT_LOAD_PC = 6'd16
    } car_state_e;

    // Instruction format / opcode constants
    localparam logic [5:0]  FMT_SINGLE = 6'b000100;  // IR[15:10]
    localparam logic [3:0]  OP_MOV     = 4'h4;       // IR[15:12]
    localparam logic [2:0]  SOP_PUSH   = 3'b100;     // IR[9:7]
    localparam logic [2:0]  SOP_CALL   = 3'b101;
    localparam logic [15:0] IR_RETI    = 16'h1300;

    // Source addressing modes (As)
    localparam logic [1:0] AS_REG = 2'b00;
    localparam logic [1:0] AS_IDX = 2'b01;
    localparam logic [1:0] AS_IND = 2'b10;
    localparam logic [1:0] AS_INC = 2'b11;

    localparam logic [3:0] REG_PC = 4'd0;
    localparam logic [3:0] REG_SR = 4'd2;
    localparam logic [3:0] REG_CG = 4'd3;

    // States that issue a bus access and wait for mem_ready.
    function automatic logic is_mem_state(input car_state_e s);
        return s inside {S_RESET, S_FETCH, S_SRC_EXT, S_SRC_READ, S_DST_EXT,
                         S_DST_READ, S_WRITE, S_PUSH_WR, S_POP_SR, S_POP_PC,
                         S_INT_PUSH_PC, S_INT_PUSH_SR, S_INT_LOAD_PC};
    endfunction

    function automatic logic is_wr_state(input car_state_e s);
        return s inside {S_WRITE, S_PUSH_WR, S_INT_PUSH_PC, S_INT_PUSH_SR};
    endfunction

endpackage

// File: rtl/car_route_decode.sv
// car_route_decode
//   Combinational IR decode feeding the sequencer's routing decisions.
//   Ports:
//     i_ir              latched instruction word
//     o_is_jump         jump format or unrecognised opcode (runs as NOP EXEC)
//     o_is_reti         RETI
//     o_need_src_ext    source extension word fetch (indexed or immediate)
//     o_need_src_read   source operand read
//     o_need_dst        two-op with Ad=1 (destination extension word)
//     o_need_dst_read   destination read (Ad=1 and not MOV)
//     o_is_push_call    PUSH or CALL
//     o_writeback       EXEC is followed by WRITE
module car_route_decode
    import car_sequencer_pkg::*;
(
    input  logic [15:0] i_ir,
    output logic        o_is_jump,
    output logic        o_is_reti,
    output logic        o_need_src_ext,
    output logic        o_need_src_read,
    output logic        o_need_dst,
    output logic        o_need_dst_read,
    output logic        o_is_push_call,
    output logic        o_writeback
);
    logic       w_two_op, w_single, w_cg, w_imm, w_src_op;
    logic [3:0] w_src;
    logic [1:0] w_as;

    assign w_two_op = i_ir[15:12] >= 4'h4;
    assign w_single = i_ir[15:10] == FMT_SINGLE;
    assign w_src    = w_two_op ? i_ir[11:8] : i_ir[3:0];
    assign w_as     = i_ir[5:4];

    // Constant generator: R3 in any mode, R2 in modes 1x; no bus traffic.
    assign w_cg  = (w_src == REG_CG) || (w_src == REG_SR && w_as[1]);
    assign w_imm = (w_src == REG_PC) && (w_as == AS_INC);

    // Anything below 0x4000 that is not single-op is a jump or an
    // unrecognised opcode; both run as a single EXEC.
    assign o_is_jump = !w_two_op && !w_single;
    assign o_is_reti = i_ir == IR_RETI;

    assign w_src_op        = !o_is_jump && !o_is_reti && !w_cg;
    assign o_need_src_ext  = w_src_op && (w_as == AS_IDX || w_imm);
    // Immediate only needs the extension word; indirect modes only the read.
    assign o_need_src_read = w_src_op && (w_as == AS_IDX || (w_as[1] && !w_imm));

    assign o_need_dst      = w_two_op && i_ir[7];
    assign o_need_dst_read = o_need_dst && (i_ir[15:12] != OP_MOV);

    assign o_is_push_call  = w_single && !o_is_reti &&
                             (i_ir[9:7] == SOP_PUSH || i_ir[9:7] == SOP_CALL);

    // Single-op results go back to memory only for memory-mode operands.
    assign o_writeback = o_need_dst ||
                         (w_single && !o_is_reti && !o_is_push_call &&
                          w_as != AS_REG && !w_cg && !w_imm);

endmodule

// File: rtl/car_sequencer.sv
// car_sequencer
//   Micro-sequencer for the ControlUnit: holds CAR and IR and walks each
//   instruction through fetch, operand, execute and write phases, with
//   interrupt entry at instruction boundaries.
//   Ports:
//     MCLK        clock, all state on rising edge
//     reset       synchronous active-high reset
//     MDB_in      memory read data (instruction word)
//     mem_ready   memory access completes this cycle
//     int_req     maskable interrupt pending (level)
//     GIE         SR.GIE
//     CAR         current micro-state
//     IR          latched instruction word
//     mem_req     memory access requested (decoded from CAR)
//     mem_wr      write access
//     INTACK      high while in INT_VECTOR
//     instr_done  one-cycle pulse, high in the first cycle after the
//                 instruction-boundary transition (into FETCH or INT_PUSH_PC)
module car_sequencer
    import car_sequencer_pkg::*;
#(
    parameter int CAR_BITS   = 6,
    parameter bit INT_ENABLE = 1'b1
) (
    input  logic                MCLK,
    input  logic                reset,
    input  logic [15:0]         MDB_in,
    input  logic                mem_ready,
    input  logic                int_req,
    input  logic                GIE,
    output logic [CAR_BITS-1:0] CAR,
    output logic [15:0]         IR,
    output logic                mem_req,
    output logic                mem_wr,
    output logic                INTACK,
    output logic                instr_done
);
    car_state_e  r_car;
    logic [15:0] r_ir;
    logic        r_instr_done;

    logic w_is_jump, w_is_reti, w_need_src_ext, w_need_src_read;
    logic w_need_dst, w_need_dst_read, w_is_push_call, w_writeback;
    logic w_hold;
    car_state_e w_phase, w_boundary;

    car_route_decode u_decode (
        .i_ir            (r_ir),
        .o_is_jump       (w_is_jump),
        .o_is_reti       (w_is_reti),
        .o_need_src_ext  (w_need_src_ext),
        .o_need_src_read (w_need_src_read),
        .o_need_dst      (w_need_dst),
        .o_need_dst_read (w_need_dst_read),
        .o_is_push_call  (w_is_push_call),
        .o_writeback     (w_writeback)
    );

    // Phase after the source operand is resolved.
    always_comb begin
        w_phase = S_EXEC;
        if (w_need_dst)          w_phase = S_DST_EXT;
        else if (w_is_push_call) w_phase = S_PUSH_DEC;
    end

    // int_req only matters here; mid-instruction requests wait.
    assign w_boundary = (INT_ENABLE && int_req && GIE) ? S_INT_PUSH_PC : S_FETCH;
    assign w_hold     = is_mem_state(r_car) && !mem_ready;

    always_ff @(posedge MCLK) begin
        if (reset) begin
            r_car        <= S_RESET;
            r_ir         <= 16'h0000;
            r_instr_done <= 1'b0;
        end else begin
            r_instr_done <= 1'b0;
            if (!w_hold) begin
                case (r_car)
                    S_RESET:  r_car <= S_FETCH;
                    S_FETCH: begin
                        r_ir  <= MDB_in;
                        r_car <= S_DECODE;
                    end
                    S_DECODE: begin
                        if (w_is_jump)            r_car <= S_EXEC;
                        else if (w_is_reti)       r_car <= S_POP_SR;
                        else if (w_need_src_ext)  r_car <= S_SRC_EXT;
                        else if (w_need_src_read) r_car <= S_SRC_READ;
                        else                      r_car <= w_phase;
                    end
                    S_SRC_EXT:  r_car <= w_need_src_read ? S_SRC_READ : w_phase;
                    S_SRC_READ: r_car <= w_phase;
                    S_DST_EXT:  r_car <= w_need_dst_read ? S_DST_READ : S_EXEC;
                    S_DST_READ: r_car <= S_EXEC;
                    S_EXEC: begin
                        if (w_writeback) begin
                            r_car <= S_WRITE;
                        end else begin
                            r_car        <= w_boundary;
                            r_instr_done <= 1'b1;
                        end
                    end
                    S_WRITE, S_PUSH_WR, S_POP_PC: begin
                        r_car        <= w_boundary;
                        r_instr_done <= 1'b1;
                    end
                    S_PUSH_DEC:    r_car <= S_PUSH_WR;
                    S_POP_SR:      r_car <= S_POP_PC;
                    S_INT_PUSH_PC: r_car <= S_INT_PUSH_SR;
                    S_INT_PUSH_SR: r_car <= S_INT_VECTOR;
                    S_INT_VECTOR:  r_car <= S_INT_LOAD_PC;
                    S_INT_LOAD_PC: r_car <= S_FETCH;
                    default:       r_car <= S_RESET;
                endcase
            end
        end
    end

    assign CAR        = CAR_BITS'(r_car);
    assign IR         = r_ir;
    // Gated by reset so the bus stays idle while reset is held.
    assign mem_req    = is_mem_state(r_car) && !reset;
    assign mem_wr     = is_wr_state(r_car) && !reset;
    assign INTACK     = r_car == S_INT_VECTOR;
    assign instr_done = r_instr_done;

endmodule

// File: tb/tb_car_sequencer.sv
module tb_car_sequencer;
    logic        MCLK = 1'b0;
    logic        reset, mem_ready, int_req, GIE;
    logic [15:0] MDB_in;
    logic [5:0]  CAR;
    logic [15:0] IR;
    logic        mem_req, mem_wr, INTACK, instr_done;

    typedef struct {
        logic [5:0]  car;
        logic        done;
        logic        ack;
        logic [15:0] ir;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] cur_ir = 16'h0000;

    always #5 MCLK = ~MCLK;

    car_sequencer dut (
        .MCLK       (MCLK),
        .reset      (reset),
        .MDB_in     (MDB_in),
        .mem_ready  (mem_ready),
        .int_req    (int_req),
        .GIE        (GIE),
        .CAR        (CAR),
        .IR         (IR),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .INTACK     (INTACK),
        .instr_done (instr_done)
    );

    function automatic logic mem_st(input logic [5:0] c);
        return c inside {6'd0, 6'd1, 6'd3, 6'd4, 6'd5, 6'd6, 6'd8, 6'd10,
                         6'd11, 6'd12, 6'd13, 6'd14, 6'd16};
    endfunction

    function automatic logic wr_st(input logic [5:0] c);
        return c inside {6'd8, 6'd10, 6'd13, 6'd14};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input logic [5:0] c, input logic d, input logic a);
        exp_t e;
        e.car = c; e.done = d; e.ack = a; e.ir = cur_ir;
        exp_q.push_back(e);
    endtask

    task automatic load(input logic [15:0] ir);
        MDB_in = ir;
        cur_ir = ir;
    endtask

    // One clock per queued expectation; compare #1 after the edge.
    task automatic drain();
        exp_t e;
        while (exp_q.size() != 0) begin
            @(posedge MCLK); #1;
            e = exp_q.pop_front();
            chk("CAR",        32'(CAR),        32'(e.car));
            chk("instr_done", 32'(instr_done), 32'(e.done));
            chk("INTACK",     32'(INTACK),     32'(e.ack));
            chk("IR",         32'(IR),         32'(e.ir));
            chk("mem_req",    32'(mem_req),    32'(mem_st(e.car) && !reset));
            chk("mem_wr",     32'(mem_wr),     32'(wr_st(e.car) && !reset));
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; int_req = 1'b0; GIE = 1'b0; MDB_in = 16'h0000;
        repeat (2) @(posedge MCLK);
        #1;
        chk("rst_CAR",   32'(CAR),        32'd0);
        chk("rst_IR",    32'(IR),         32'd0);
        chk("rst_done",  32'(instr_done), 32'd0);
        chk("rst_ack",   32'(INTACK),     32'd0);
        chk("rst_req",   32'(mem_req),    32'd0);
        chk("rst_wr",    32'(mem_wr),     32'd0);
        reset = 1'b0;
        push(1, 0, 0); drain();

        // MOV R4,R10
        load(16'h440A); push(2,0,0); push(7,0,0); push(1,1,0); drain();
        // MOV X(R5),Y(R11): no DST_READ
        load(16'h459B);
        push(2,0,0); push(3,0,0); push(4,0,0); push(5,0,0); push(7,0,0); push(8,0,0); push(1,1,0);
        drain();
        // ADD X(R5),Y(R11): DST_READ visited
        load(16'h559B);
        push(2,0,0); push(3,0,0); push(4,0,0); push(5,0,0); push(6,0,0); push(7,0,0); push(8,0,0);
        push(1,1,0); drain();
        // ADD #1,R6 via constant generator
        load(16'h5316); push(2,0,0); push(7,0,0); push(1,1,0); drain();
        // MOV #N,R5 immediate: SRC_EXT only
        load(16'h4035); push(2,0,0); push(3,0,0); push(7,0,0); push(1,1,0); drain();
        // ADD @R5,R6 with 3 wait cycles in SRC_READ
        load(16'h5526); push(2,0,0); push(4,0,0); drain();
        mem_ready = 1'b0; push(4,0,0); push(4,0,0); push(4,0,0); drain();
        mem_ready = 1'b1; push(7,0,0); push(1,1,0); drain();
        // RRC @R5: single-op with writeback
        load(16'h1025); push(2,0,0); push(4,0,0); push(7,0,0); push(8,0,0); push(1,1,0); drain();
        // PUSH R5
        load(16'h1205); push(2,0,0); push(9,0,0); push(10,0,0); push(1,1,0); drain();
        // RETI
        load(16'h1300); push(2,0,0); push(11,0,0); push(12,0,0); push(1,1,0); drain();
        // JMP, and two unrecognised opcodes run as NOP
        load(16'h3C05); push(2,0,0); push(7,0,0); push(1,1,0); drain();
        load(16'h0000); push(2,0,0); push(7,0,0); push(1,1,0); drain();
        load(16'h1400); push(2,0,0); push(7,0,0); push(1,1,0); drain();

        // Interrupt raised in EXEC, GIE=1
        load(16'h440A); push(2,0,0); push(7,0,0); drain();
        int_req = 1'b1; GIE = 1'b1; push(13,1,0); drain();
        int_req = 1'b0; push(14,0,0); push(15,0,1); push(16,0,0); push(1,0,0); drain();
        // Same with GIE=0: no entry
        load(16'h440A); push(2,0,0); push(7,0,0); drain();
        int_req = 1'b1; GIE = 1'b0; push(1,1,0); drain();
        int_req = 1'b0;
        // Request raised at DECODE waits until the boundary
        load(16'h459B); push(2,0,0); drain();
        int_req = 1'b1; GIE = 1'b1;
        push(3,0,0); push(4,0,0); push(5,0,0); push(7,0,0); push(8,0,0); push(13,1,0); drain();
        int_req = 1'b0; push(14,0,0); push(15,0,1); push(16,0,0); push(1,0,0); drain();

        // Reset during INT_VECTOR
        load(16'h440A); push(2,0,0); push(7,0,0); drain();
        int_req = 1'b1; push(13,1,0); drain();
        int_req = 1'b0; push(14,0,0); push(15,0,1); drain();
        reset = 1'b1; cur_ir = 16'h0000; push(0,0,0); drain();
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
